execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter FLUSH_DEPTH, default 2: number of in_valid instructions squashed after a redirect.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  decoded instruction present this cycle.
REQ-005 pc  input  32  address of the presented instruction.
REQ-006 instr  input  32  raw instruction word, used for immediate generation.
REQ-007 opcode / funct3 / funct7 / rd  input  7/3/7/5  decoded fields of instr.
REQ-008 readData1 / readData2  input  32/32  register-file values for rs1 / rs2.
REQ-009 out_valid  output  1  registered result valid.
REQ-010 regWrite  output  1  write-back enable.
REQ-011 wb_rd  output  5  write-back destination.
REQ-012 writeData  output  32  write-back value.
REQ-013 branch_taken  output  1  conditional branch resolved taken.
REQ-014 branch_tgt  output  32  branch target.
REQ-015 jump  output  1  JAL/JALR redirect.
REQ-016 jump_tgt  output  32  jump target.

Function
REQ-017 All outputs SHALL be registered, with exactly 1-cycle latency from an accepted in_valid to out_valid.
REQ-018 With in_valid=0 or the instruction squashed: out_valid, regWrite, branch_taken and jump SHALL be 0 next cycle, and the data outputs SHALL hold their previous values.
REQ-019 Immediates SHALL be sign-extended per RV32I: I, S, B (bit0=0), U (low 12 bits zero) and J (bit0=0) formats.
REQ-020 OP (0110011) SHALL implement ADD/SUB (funct7[5]), SLL, SLT, SLTU, XOR, SRL/SRA (funct7[5]), OR and AND; shift amount is rs2[4:0].
REQ-021 OP-IMM (0010011) SHALL implement the same set minus SUB; shifts SHALL use instr[24:20], with SRAI selected by funct7[5].
REQ-022 LUI (0110111): writeData=imm_u. AUIPC (0010111): writeData=pc+imm_u.
REQ-023 JAL (1101111): writeData=pc+4, jump=1, jump_tgt=pc+imm_j.
REQ-024 JALR (1100111): writeData=pc+4, jump=1, jump_tgt=(readData1+imm_i) with bit0 cleared.
REQ-025 BRANCH (1100011): BEQ/BNE/BLT/BGE/BLTU/BGEU on readData1 vs readData2 (signed/unsigned per funct3); branch_tgt=pc+imm_b always; branch_taken=condition; regWrite=0.
REQ-026 All arithmetic SHALL be modulo 2^32; carries and overflow are discarded; no exceptions on misaligned targets.
REQ-027 regWrite SHALL be 1 only for OP, OP-IMM, LUI, AUIPC, JAL and JALR with rd!=0; wb_rd=rd.
REQ-028 Unsupported opcode or funct3: out_valid=1, regWrite=0, no redirect.
REQ-029 Squash FSM states: RUN and FLUSH(count). A redirect (branch_taken or jump) SHALL load count=FLUSH_DEPTH and enter FLUSH.
REQ-030 In FLUSH, each in_valid=1 cycle SHALL be squashed and decrement count; cycles with in_valid=0 SHALL not decrement. At count 0 the FSM SHALL return to RUN.
REQ-031 A squashed instruction SHALL never generate a redirect or a write-back; a redirect cannot restart FLUSH while already in FLUSH.
REQ-032 branch_taken and jump SHALL be mutually exclusive and single-cycle pulses per instruction.

Reset
REQ-033 While reset=1 at a clock edge: out_valid, regWrite, branch_taken and jump SHALL be 0; wb_rd=0; writeData, branch_tgt and jump_tgt SHALL be 0; the FSM SHALL be in RUN with count=0.
REQ-034 Reset asserted mid-FLUSH SHALL abandon the flush, and the first in_valid after release SHALL execute normally.

Verification
REQ-035 ADD, rd=3, readData1=0x00ABCD11, readData2=0x1 -> next cycle out_valid=1, regWrite=1, wb_rd=3, writeData=0x00ABCD12.
REQ-036 SRAI shamt 4 on readData1=0x80000000 -> writeData=0xF8000000; the same with SRLI -> 0x08000000.
REQ-037 BEQ at pc=0x0, imm_b=8, equal operands -> branch_taken=1, branch_tgt=0x8; the next 2 in_valid instructions produce out_valid=0; the third executes.
REQ-038 JALR rd=1, pc=0x10, readData1=0x0D, imm=0 -> jump=1, jump_tgt=0x0C, writeData=0x14; a JAL among the two squashed instructions produces no jump.
REQ-039 ADDI with rd=0 -> out_valid=1, regWrite=0; BLTU 0xFFFFFFFF vs 0x1 -> not taken; BLT with the same operands -> taken.
REQ-040 Reset pulsed one cycle after a taken branch -> all outputs 0; an ADD presented after release is not squashed.

Source files
------------

// File: rtl/execute_stage.sv
// RV32I execute stage: ALU, immediate generation, branch/jump resolution and a
// squash FSM that discards the next FLUSH_DEPTH valid instructions after a redirect.
module execute_stage #(
  parameter int FLUSH_DEPTH = 2,
  parameter int CW = (FLUSH_DEPTH < 1) ? 1 : $clog2(FLUSH_DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [31:0]   pc,
  input  logic [31:0]   instr,
  input  logic [6:0]    opcode,
  input  logic [2:0]    funct3,
  input  logic [6:0]    funct7,
  input  logic [4:0]    rd,
  input  logic [31:0]   readData1,
  input  logic [31:0]   readData2,
  output logic          out_valid,
  output logic          regWrite,
  output logic [4:0]    wb_rd,
  output logic [31:0]   writeData,
  output logic          branch_taken,
  output logic [31:0]   branch_tgt,
  output logic          jump,
  output logic [31:0]   jump_tgt,
  output logic          flush_state,
  output logic [CW-1:0] flush_count
);
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JLR = 7'b1100111;
  localparam logic [6:0] OP_BR  = 7'b1100011;

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;
  state_t state;

  logic [31:0] imm_i, imm_b, imm_u, imm_j;
  logic [31:0] op_b, res, b_tgt, j_tgt;
  logic [4:0]  shamt;
  logic        wen, br, jp, accept;

  // Decoded fields arrive separately, so the opcode/funct7 bits of instr are unused here.
  logic unused_bits;
  assign unused_bits = &{1'b0, instr[6:0], funct7[6], funct7[4:0]};

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'h000};
  assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

  assign accept      = in_valid && (state == RUN);
  assign flush_state = (state == FLUSH);

  always_comb begin
    res   = 32'h0;
    wen   = 1'b0;
    br    = 1'b0;
    jp    = 1'b0;
    b_tgt = pc + imm_b;
    j_tgt = pc + imm_j;
    op_b  = (opcode == OP_R) ? readData2 : imm_i;
    shamt = (opcode == OP_R) ? readData2[4:0] : instr[24:20];
    case (opcode)
      OP_R, OP_IMM: begin
        wen = 1'b1;
        case (funct3)
          3'b000: res = (opcode == OP_R && funct7[5]) ? readData1 - op_b : readData1 + op_b;
          3'b001: res = readData1 << shamt;
          3'b010: res = {31'h0, $signed(readData1) < $signed(op_b)};
          3'b011: res = {31'h0, readData1 < op_b};
          3'b100: res = readData1 ^ op_b;
          3'b101: res = funct7[5] ? 32'($signed(readData1) >>> shamt) : readData1 >> shamt;
          3'b110: res = readData1 | op_b;
          default: res = readData1 & op_b;
        endcase
      end
      OP_LUI: begin res = imm_u;      wen = 1'b1; end
      OP_AUI: begin res = pc + imm_u; wen = 1'b1; end
      OP_JAL: begin res = pc + 32'd4; wen = 1'b1; jp = 1'b1; end
      OP_JLR: begin
        j_tgt = (readData1 + imm_i) & ~32'h1;
        if (funct3 == 3'b000) begin
          res = pc + 32'd4;
          wen = 1'b1;
          jp  = 1'b1;
        end
      end
      OP_BR: begin
        case (funct3)
          3'b000: br = (readData1 == readData2);
          3'b001: br = (readData1 != readData2);
          3'b100: br = ($signed(readData1) < $signed(readData2));
          3'b101: br = ($signed(readData1) >= $signed(readData2));
          3'b110: br = (readData1 < readData2);
          3'b111: br = (readData1 >= readData2);
          default: br = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid    <= 1'b0;
      regWrite     <= 1'b0;
      branch_taken <= 1'b0;
      jump         <= 1'b0;
      wb_rd        <= 5'd0;
      writeData    <= 32'h0;
      branch_tgt   <= 32'h0;
      jump_tgt     <= 32'h0;
      state        <= RUN;
      flush_count  <= '0;
    end else begin
      out_valid    <= accept;
      regWrite     <= accept && wen && (rd != 5'd0);
      branch_taken <= accept && br;
      jump         <= accept && jp;
      if (accept) begin
        wb_rd      <= rd;
        writeData  <= res;
        branch_tgt <= b_tgt;
        jump_tgt   <= j_tgt;
      end
      // Only an accepted (RUN-state) instruction can start a flush, so FLUSH never restarts.
      case (state)
        RUN: if (accept && (br || jp) && FLUSH_DEPTH > 0) begin
          state       <= FLUSH;
          flush_count <= CW'(FLUSH_DEPTH);
        end
        FLUSH: if (in_valid) begin
          flush_count <= flush_count - CW'(1);
          if (flush_count == CW'(1)) state <= RUN;
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_stage.sv
// Directed-vector bench for execute_stage: hand-computed results for ALU ops,
// immediates, branches, jumps, the squash window and reset during a flush.
module tb_execute_stage;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] pc, instr, readData1, readData2;
  logic [6:0]  opcode, funct7;
  logic [2:0]  funct3;
  logic [4:0]  rd;
  logic        out_valid, regWrite, branch_taken, jump, flush_state;
  logic [4:0]  wb_rd;
  logic [31:0] writeData, branch_tgt, jump_tgt;
  logic [1:0]  flush_count;
  int          total = 0;
  int          bad = 0;

  execute_stage #(.FLUSH_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .pc(pc), .instr(instr),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd),
    .readData1(readData1), .readData2(readData2),
    .out_valid(out_valid), .regWrite(regWrite), .wb_rd(wb_rd), .writeData(writeData),
    .branch_taken(branch_taken), .branch_tgt(branch_tgt), .jump(jump), .jump_tgt(jump_tgt),
    .flush_state(flush_state), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] d);
    return {f7, 5'd2, 5'd1, f3, d, 7'b0110011};
  endfunction
  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                         input logic [4:0] d, input logic [6:0] op);
    return {imm, 5'd1, f3, d, op};
  endfunction
  function automatic logic [31:0] b_type(input logic [12:0] imm, input logic [2:0] f3);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_type(input logic [20:0] imm, input logic [4:0] d);
    return {imm[20], imm[10:1], imm[11], imm[19:12], d, 7'b1101111};
  endfunction

  task automatic exec(input logic [31:0] w, input logic [31:0] p,
                      input logic [31:0] a, input logic [31:0] b);
    in_valid = 1'b1; instr = w; pc = p; readData1 = a; readData2 = b;
    opcode = w[6:0]; rd = w[11:7]; funct3 = w[14:12]; funct7 = w[31:25];
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  localparam logic [31:0] ADD_R3 = 32'h0020_01B3;

  initial begin
    reset = 1'b1; in_valid = 1'b0; pc = '0; instr = '0; readData1 = '0; readData2 = '0;
    opcode = '0; funct3 = '0; funct7 = '0; rd = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", out_valid, 0);   check("rst_wen", regWrite, 0);
    check("rst_br", branch_taken, 0);   check("rst_jmp", jump, 0);
    check("rst_rd", wb_rd, 0);          check("rst_wd", writeData, 0);
    check("rst_btgt", branch_tgt, 0);   check("rst_jtgt", jump_tgt, 0);
    check("rst_state", flush_state, 0); check("rst_cnt", flush_count, 0);
    reset = 1'b0;

    exec(r_type(7'h00, 3'b000, 5'd3), 32'h0, 32'h00AB_CD11, 32'h1);
    check("add_valid", out_valid, 1); check("add_wen", regWrite, 1);
    check("add_rd", wb_rd, 3);        check("add_wd", writeData, 32'h00AB_CD12);
    exec(r_type(7'h20, 3'b000, 5'd4), 32'h4, 32'd5, 32'd7);
    check("sub_wd", writeData, 32'hFFFF_FFFE);
    exec(r_type(7'h00, 3'b001, 5'd4), 32'h4, 32'h1, 32'h24);
    check("sll_wd", writeData, 32'h10);
    exec(r_type(7'h00, 3'b010, 5'd4), 32'h4, 32'hFFFF_FFFF, 32'h1);
    check("slt_wd", writeData, 1);
    exec(r_type(7'h00, 3'b011, 5'd4), 32'h4, 32'hFFFF_FFFF, 32'h1);
    check("sltu_wd", writeData, 0);
    exec(r_type(7'h20, 3'b101, 5'd4), 32'h4, 32'hF000_0000, 32'h24);
    check("sra_wd", writeData, 32'hFF00_0000);
    exec(r_type(7'h00, 3'b100, 5'd4), 32'h4, 32'hFF00_FF00, 32'h0F0F_0F0F);
    check("xor_wd", writeData, 32'hF00F_F00F);

    exec(i_type(12'h404, 3'b101, 5'd5, 7'b0010011), 32'h8, 32'h8000_0000, 32'h0);
    check("srai_wd", writeData, 32'hF800_0000);
    exec(i_type(12'h004, 3'b101, 5'd5, 7'b0010011), 32'h8, 32'h8000_0000, 32'h0);
    check("srli_wd", writeData, 32'h0800_0000);
    idle();
    check("idle_valid", out_valid, 0); check("idle_wen", regWrite, 0);
    check("idle_hold", writeData, 32'h0800_0000);
    exec(i_type(12'h800, 3'b110, 5'd5, 7'b0010011), 32'h8, 32'h1, 32'h0);
    check("ori_wd", writeData, 32'hFFFF_F801);
    exec(i_type(12'hFFF, 3'b111, 5'd5, 7'b0010011), 32'h8, 32'h1234, 32'h0);
    check("andi_wd", writeData, 32'h1234);
    exec({20'h12345, 5'd6, 7'b0110111}, 32'h100, 32'h0, 32'h0);
    check("lui_wd", writeData, 32'h1234_5000);
    exec({20'h00001, 5'd6, 7'b0010111}, 32'h100, 32'h0, 32'h0);
    check("auipc_wd", writeData, 32'h0000_1100);
    exec(i_type(12'h005, 3'b000, 5'd0, 7'b0010011), 32'h100, 32'h1, 32'h0);
    check("addi_x0_valid", out_valid, 1); check("addi_x0_wen", regWrite, 0);
    exec({25'h0, 7'b1111111}, 32'h104, 32'h0, 32'h0);
    check("bad_op_valid", out_valid, 1); check("bad_op_wen", regWrite, 0);
    check("bad_op_jmp", jump, 0);        check("bad_op_br", branch_taken, 0);

    // BEQ taken, squash window with an idle gap in the middle
    exec(b_type(13'd8, 3'b000), 32'h0, 32'd5, 32'd5);
    check("beq_taken", branch_taken, 1); check("beq_tgt", branch_tgt, 32'h8);
    check("beq_jmp", jump, 0);           check("beq_wen", regWrite, 0);
    check("beq_cnt", flush_count, 2);
    exec(ADD_R3, 32'h4, 32'h1, 32'h1);
    check("sq1_valid", out_valid, 0); check("sq1_br", branch_taken, 0);
    check("sq1_wen", regWrite, 0);
    idle();
    check("gap_state", flush_state, 1); check("gap_cnt", flush_count, 1);
    exec(ADD_R3, 32'h8, 32'h1, 32'h1);
    check("sq2_valid", out_valid, 0);
    exec(ADD_R3, 32'h8, 32'h2, 32'h3);
    check("post_beq_valid", out_valid, 1); check("post_beq_wd", writeData, 5);

    // JALR, then a JAL inside the squash window, then an executed JAL
    exec(i_type(12'h000, 3'b000, 5'd1, 7'b1100111), 32'h10, 32'h0D, 32'h0);
    check("jalr_jmp", jump, 1);        check("jalr_tgt", jump_tgt, 32'h0C);
    check("jalr_wd", writeData, 32'h14); check("jalr_wen", regWrite, 1);
    check("jalr_rd", wb_rd, 1);        check("jalr_br", branch_taken, 0);
    exec(j_type(21'h100, 5'd1), 32'h0C, 32'h0, 32'h0);
    check("sq_jal_jmp", jump, 0); check("sq_jal_valid", out_valid, 0);
    check("sq_jal_wen", regWrite, 0);
    exec(i_type(12'h001, 3'b000, 5'd2, 7'b0010011), 32'h10, 32'h0, 32'h0);
    check("sq_addi_valid", out_valid, 0); check("sq_state", flush_state, 0);
    exec(j_type(21'h1F_FFF0, 5'd1), 32'h40, 32'h0, 32'h0);
    check("jal_jmp", jump, 1);  check("jal_tgt", jump_tgt, 32'h30);
    check("jal_wd", writeData, 32'h44);
    exec(ADD_R3, 32'h30, 32'h0, 32'h0);
    check("jal_sq1", out_valid, 0); check("jal_sq1_jmp", jump, 0);
    exec(ADD_R3, 32'h34, 32'h0, 32'h0);
    check("jal_sq2", out_valid, 0);

    exec(b_type(13'h1FF8, 3'b110), 32'h20, 32'hFFFF_FFFF, 32'h1);
    check("bltu_taken", branch_taken, 0); check("bltu_tgt", branch_tgt, 32'h18);
    check("bltu_state", flush_state, 0);
    exec(b_type(13'h1FF8, 3'b100), 32'h20, 32'hFFFF_FFFF, 32'h1);
    check("blt_taken", branch_taken, 1); check("blt_tgt", branch_tgt, 32'h18);

    // reset lands in the middle of the flush triggered by BLT
    reset = 1'b1;
    idle();
    reset = 1'b0;
    check("mid_rst_valid", out_valid, 0); check("mid_rst_br", branch_taken, 0);
    check("mid_rst_btgt", branch_tgt, 0); check("mid_rst_wd", writeData, 0);
    check("mid_rst_state", flush_state, 0); check("mid_rst_cnt", flush_count, 0);
    exec(ADD_R3, 32'h18, 32'h10, 32'h20);
    check("post_rst_valid", out_valid, 1); check("post_rst_wd", writeData, 32'h30);
    check("post_rst_wen", regWrite, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
